seq_pattern_transmitter: RTL and testbench
==========================================

Name: seq_pattern_transmitter

Overview:
Serial pattern generator. It is the transmit end of the serial bit stream consumed by the team's sequence-detector FSMs. It loads a programmable bit pattern of 1..MAX_LEN bits and shifts it out MSB-first on a single serial line, one bit per DIV clocks, repeated a programmable number of times. It has a start/busy/done handshake and an abort. On the DE1-SoC its w output drives the detector's w input directly, as a self-test stimulus source.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (width of pattern port).
LEN_W, 4, width of length port; must hold MAX_LEN.
DIV, 1, clocks per transmitted bit (1 = one bit per clock); must be >= 1.
REP_W, 4, width of repeat_count port.

Ports:
clock  input  1  system clock; all state updates on rising edge.
resetn  input  1  asynchronous, active-low reset.
start  input  1  request transmission; sampled only in IDLE.
pattern  input  MAX_LEN  bits to send; pattern[length-1] goes out first, pattern[0] last.
length  input  LEN_W  number of pattern bits to send.
repeat_count  input  REP_W  number of back-to-back pattern transmissions; 0 treated as 1.
abort  input  1  synchronous cancel of an in-progress transmission.
w  output  1  serial data bit (registered).
w_valid  output  1  high while w carries a pattern bit.
busy  output  1  high from the cycle after an accepted start until return to IDLE/DONE.
done  output  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Clock and reset: one clock (clock). Reset is asynchronous and active-low (resetn).
- While resetn=0: state=IDLE; w=0, w_valid=0, busy=0, done=0; all counters and latches cleared. Reset asserted mid-transmission aborts immediately; no done pulse is produced.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, SEND, DONE.
- IDLE:
  - start=1 with length!=0 is accepted at that edge.
  - On acceptance, latch pattern, length (clamped to MAX_LEN if larger) and repeat_count (0 becomes 1).
  - Initialise bit index = length-1, rep counter = 0, div counter = 0.
  - Next state is SEND.
  - start with length=0 is ignored: remains IDLE, no busy, no done.
- SEND:
  - w = latched_pattern[bit index]; w_valid=1; busy=1.
  - Latency: start accepted at edge k means the first bit is visible on w after edge k, and is held for DIV clocks.
  - Each bit is held exactly DIV clocks. The div counter counts 0..DIV-1, then the bit index decrements.
  - After bit index 0: if rep+1 < latched repeat, reload the bit index to length-1 and increment rep. The next repetition's first bit follows the previous last bit with no gap.
  - After bit 0 of the final repetition, the next state is DONE.
- DONE: exactly one cycle with done=1, busy=0, w_valid=0, w=0. Next state is IDLE. A start during DONE is ignored.
- start while in SEND is ignored. Input changes on pattern, length or repeat_count after acceptance have no effect.
- abort=1 in SEND: next state is IDLE. w, w_valid and busy are 0 from the following cycle; no done pulse. abort in IDLE or DONE has no effect.
- abort and start asserted together in IDLE: abort has no effect and start is accepted.
- Total SEND duration = length × repeat × DIV clocks.
- Outside SEND, w is held at 0.

Test Plan:
1. DIV=1, pattern=8'b0000_0110, length=3, repeat=1, start pulse at edge k:
   - w=1,1,0 in cycles k+1..k+3, w_valid high exactly those 3 cycles.
   - done=1 in cycle k+4, busy low again in k+4.
   - A connected seq110_detector asserts z in the cycle after its state register captures the final 0.
2. DIV=1, pattern=3'b110, length=3, repeat=2:
   - w=1,1,0,1,1,0 contiguous over 6 cycles.
   - done pulses once only, in cycle k+7.
   - repeat_count=0 with the same stimulus produces the same output as repeat=1.
3. DIV=4, pattern=8'b1010_0001, length=8:
   - Each bit is held 4 cycles; w_valid is high 32 cycles; sequence is 1,0,1,0,0,0,0,1.
   - length=12 is clamped and gives the identical 32-cycle result.
4. length=0 with start: busy, w_valid and done stay 0 for 10 cycles. Then start with length=2 is accepted normally.
5. start re-asserted mid-SEND with a different pattern: the original stream completes unchanged. abort asserted at the 2nd bit: w_valid and busy drop the next cycle, done never pulses, and a new start is accepted from IDLE.
6. resetn pulsed low asynchronously (between clock edges) mid-SEND: outputs go to 0 immediately with no clock edge needed. After release, the block is IDLE and a fresh start transmits correctly.

Source files
------------

// File: rtl/seq_pattern_transmitter.sv
// seq_pattern_transmitter: shifts a programmable pattern out MSB-first on w, DIV clocks per bit, repeated N times.
module seq_pattern_transmitter #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int DIV     = 1,
    parameter int REP_W   = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   length,
    input  logic [REP_W-1:0]   repeat_count,
    input  logic               abort,
    output logic               w,
    output logic               w_valid,
    output logic               busy,
    output logic               done
);
    localparam int IDX_W = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int DIV_W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t             r_state, w_state;
    logic [MAX_LEN-1:0] r_pat, w_pat;
    logic [IDX_W-1:0]   r_last, w_last, r_idx, w_idx;
    logic [REP_W-1:0]   r_rep, w_rep, r_rcnt, w_rcnt;
    logic [DIV_W-1:0]   r_div, w_div;
    logic               r_w, r_valid, r_busy, r_done;
    logic [LEN_W-1:0]   w_len;
    logic               w_bit_end, w_last_rep;

    assign w_len      = (length > MAX_L) ? MAX_L : length;
    assign w_bit_end  = r_div == DIV_MAX;
    assign w_last_rep = r_rcnt == r_rep - 1'b1;

    always_comb begin
        w_state = r_state;
        w_pat   = r_pat;
        w_last  = r_last;
        w_idx   = r_idx;
        w_rep   = r_rep;
        w_rcnt  = r_rcnt;
        w_div   = r_div;
        case (r_state)
            IDLE: if (start && length != '0) begin
                w_state = SEND;
                w_pat   = pattern;
                w_last  = IDX_W'(w_len - 1'b1);
                w_idx   = IDX_W'(w_len - 1'b1);
                w_rep   = (repeat_count == '0) ? REP_W'(1) : repeat_count;
                w_rcnt  = '0;
                w_div   = '0;
            end
            SEND: if (abort) w_state = IDLE;
            else if (!w_bit_end) w_div = r_div + 1'b1;
            else begin
                w_div = '0;
                if (r_idx != '0) w_idx = r_idx - 1'b1;
                else if (!w_last_rep) begin
                    w_idx  = r_last;
                    w_rcnt = r_rcnt + 1'b1;
                end else w_state = DONE;
            end
            default: w_state = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the first bit appears right after the accepting edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_last  <= '0;
            r_idx   <= '0;
            r_rep   <= '0;
            r_rcnt  <= '0;
            r_div   <= '0;
            r_w     <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pat   <= w_pat;
            r_last  <= w_last;
            r_idx   <= w_idx;
            r_rep   <= w_rep;
            r_rcnt  <= w_rcnt;
            r_div   <= w_div;
            r_w     <= (w_state == SEND) && w_pat[w_idx];
            r_valid <= w_state == SEND;
            r_busy  <= w_state == SEND;
            r_done  <= w_state == DONE;
        end
    end

    assign w       = r_w;
    assign w_valid = r_valid;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule

// File: tb/tb_seq_pattern_transmitter.sv
// tb_seq_pattern_transmitter: DIV=1 and DIV=4 instances on shared stimulus, checked every cycle against a stream model.
module tb_seq_pattern_transmitter;
    localparam int ML = 8;

    logic       clock = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] length = '0, repeat_count = '0;
    logic       w1, v1, b1, d1, w4, v4, b4, d4;

    int         n_checks = 0, n_errors = 0;
    logic [3:0] eq [2][0:1023];
    int         cnt [2] = '{0, 0};
    int         pos [2] = '{0, 0};
    logic [3:0] cur [2] = '{4'h0, 4'h0};
    int         divs [2] = '{1, 4};

    seq_pattern_transmitter #(.DIV(1)) u1 (
        .clock(clock), .resetn(resetn), .start(start), .pattern(pattern), .length(length),
        .repeat_count(repeat_count), .abort(abort), .w(w1), .w_valid(v1), .busy(b1), .done(d1)
    );
    seq_pattern_transmitter #(.DIV(4)) u4 (
        .clock(clock), .resetn(resetn), .start(start), .pattern(pattern), .length(length),
        .repeat_count(repeat_count), .abort(abort), .w(w4), .w_valid(v4), .busy(b4), .done(d4)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] obs(input int d);
        return d == 0 ? {w1, v1, b1, d1} : {w4, v4, b4, d4};
    endfunction

    function automatic logic idle(input int d);
        return pos[d] == cnt[d] && cur[d] == 4'h0;
    endfunction

    // Expected outputs as a precomputed stream of {w,w_valid,busy,done} per cycle, ending in one done cycle.
    task automatic model_step(input int d);
        int len, rep, n;
        if (!resetn) begin
            cnt[d] = 0; pos[d] = 0; cur[d] = 4'h0;
        end else if (abort && cur[d][2]) begin
            cnt[d] = 0; pos[d] = 0; cur[d] = 4'h0;
        end else begin
            if (pos[d] == cnt[d] && !cur[d][0] && start && length != 0) begin
                len = int'(length) > ML ? ML : int'(length);
                rep = repeat_count == 0 ? 1 : int'(repeat_count);
                n = 0;
                for (int r = 0; r < rep; r++)
                    for (int b = len - 1; b >= 0; b--)
                        for (int k = 0; k < divs[d]; k++) begin
                            eq[d][n] = {pattern[b], 3'b110};
                            n++;
                        end
                eq[d][n] = 4'b0001;
                cnt[d] = n + 1;
                pos[d] = 0;
            end
            if (pos[d] < cnt[d]) begin
                cur[d] = eq[d][pos[d]];
                pos[d]++;
            end else cur[d] = 4'h0;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step(0);
        model_step(1);
        @(negedge clock);
        check("u1_out", 32'(obs(0)), 32'(cur[0]));
        check("u4_out", 32'(obs(1)), 32'(cur[1]));
    endtask

    task automatic settle();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 700 && !(idle(0) && idle(1)); i++) cyc();
        check("settle", 32'(idle(0) && idle(1)), 32'd1);
    endtask

    task automatic go(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern = p; length = l; repeat_count = r; start = 1'b1;
    endtask

    task automatic run_short(input logic [7:0] p, input logic [3:0] r, input int n, output logic [31:0] seq);
        seq = '0;
        go(p, 4'd3, r);
        for (int i = 0; i < n; i++) begin
            cyc();
            start = 1'b0;
            seq = {seq[27:0], obs(0)};
        end
    endtask

    initial begin
        logic [31:0] seq, bits;
        int nv, nd;
        logic [2:0] acc;
        cyc();
        cyc();
        check("reset_u1", 32'(obs(0)), 32'd0);
        check("reset_u4", 32'(obs(1)), 32'd0);
        resetn = 1'b1;
        cyc();

        run_short(8'b0000_0110, 4'd1, 5, seq);
        check("t1_seq", seq, 32'h000EE610);
        settle();
        run_short(8'b0000_0110, 4'd2, 8, seq);
        check("t2_rep2", seq, 32'hEE6EE610);
        settle();
        run_short(8'b0000_0110, 4'd0, 5, seq);
        check("t2_rep0", seq, 32'h000EE610);
        settle();

        for (int t = 0; t < 2; t++) begin
            go(8'b1010_0001, t == 0 ? 4'd8 : 4'd12, 4'd1);
            bits = '0; nv = 0; nd = 0;
            for (int i = 0; i < 35; i++) begin
                cyc();
                start = 1'b0;
                if (v4) begin bits = {bits[30:0], w4}; nv++; end
                if (d4) nd++;
            end
            check(t == 0 ? "t3_bits" : "t3_clamp_bits", bits, 32'hF0F0000F);
            check(t == 0 ? "t3_valid" : "t3_clamp_valid", 32'(nv), 32'd32);
            check(t == 0 ? "t3_done" : "t3_clamp_done", 32'(nd), 32'd1);
            settle();
        end

        acc = '0;
        go(8'hFF, 4'd0, 4'd1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            acc = acc | obs(0)[2:0] | obs(1)[2:0];
        end
        check("t4_len0", 32'(acc), 32'd0);
        go(8'b0000_0010, 4'd2, 4'd1);
        cyc();
        start = 1'b0;
        check("t4_len2", 32'(obs(0)), 32'hE);
        settle();

        go(8'hF0, 4'd8, 4'd1);
        cyc();
        go(8'h0F, 4'd5, 4'd3);
        for (int i = 0; i < 3; i++) cyc();
        start = 1'b0;
        check("t5_restart_ignored", 32'(w1), 32'd1);
        settle();

        go(8'hFF, 4'd8, 4'd1);
        cyc();
        start = 1'b0;
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("t5_abort", 32'({v1, b1}), 32'd0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            nd += int'(d1) + int'(d4);
        end
        check("t5_no_done", 32'(nd), 32'd0);
        go(8'h06, 4'd3, 4'd1);
        cyc();
        start = 1'b0;
        check("t5_restart", 32'(v1), 32'd1);
        settle();

        go(8'hAA, 4'd8, 4'd3);
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        #2 resetn = 1'b0;
        #1;
        check("t6_async_rst", {24'd0, obs(0), obs(1)}, 32'd0);
        for (int d = 0; d < 2; d++) begin cnt[d] = 0; pos[d] = 0; cur[d] = 4'h0; end
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();
        run_short(8'b0000_0110, 4'd1, 5, seq);
        check("t6_after_rst", seq, 32'h000EE610);
        settle();

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 6) == 0;
            abort = ($urandom % 40) == 0;
            pattern = 8'($urandom);
            length = 4'($urandom);
            repeat_count = 4'($urandom % 4);
            cyc();
        end
        settle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
